// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared widths, FSM state and command/response types for the APB requester
package apb_pkg;

   localparam int APB_ADDR_W         = 32;
   localparam int APB_DATA_W         = 32;
   localparam int APB_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic [APB_ADDR_W-1:0] addr;
      logic                  write;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  slverr;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_requester_if.sv
// rtl/apb_requester_if.sv - command stream, response pulse and APB completer-side signal bundle
interface apb_requester_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_write;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_slverr;
   logic              rsp_timeout;

   logic [ADDR_W-1:0] paddr;
   logic              pselx;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
      input  prdata, pready, pslverr,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      output paddr, pselx, penable, pwrite, pwdata
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
      output prdata, pready, pslverr,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      input  paddr, pselx, penable, pwrite, pwdata
   );

endinterface

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS wait-state counter, only built with APB_TIMEOUT_EN
`ifdef APB_TIMEOUT_EN
module apb_timeout_cnt
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   // High during the last allowed wait cycle, so a wait in that cycle aborts.
   assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - command stream to APB SETUP/ACCESS requester; APB_TIMEOUT_EN adds ACCESS abort
module apb_requester
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
`endif
) (
   input  logic             pclk,
   input  logic             presetn,
   apb_requester_if.master  bus
);

   apb_state_e r_state;
   apb_state_e w_state_nxt;
   apb_cmd_t   r_cmd;
   apb_rsp_t   r_rsp;
   logic       r_rsp_valid;

   logic w_cmd_ready;
   logic w_accept;
   logic w_wait;
   logic w_done;
   logic w_abort;
   logic w_rsp_block;

   assign w_wait      = (r_state == ACCESS) && !bus.pready;
   assign w_done      = (r_state == ACCESS) &&  bus.pready;
   // The cycle that reports a timeout abort must not accept a new command.
   assign w_rsp_block = r_rsp_valid && r_rsp.timeout;

`ifdef APB_TIMEOUT_EN
   logic w_expired;

   apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .i_clk     (pclk),
      .i_rst_n   (presetn),
      .i_clear   (r_state == SETUP),
      .i_inc     (w_wait),
      .o_expired (w_expired)
   );

   assign w_abort = w_wait && w_expired;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_cmd_ready = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_cmd_ready = !w_rsp_block;
         ACCESS:  w_cmd_ready = bus.pready;
         default: w_cmd_ready = 1'b0;
      endcase
      w_cmd_ready = w_cmd_ready && presetn;
      w_accept    = bus.cmd_valid && w_cmd_ready;

      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = SETUP;
         end
         SETUP: begin
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            if (w_done) begin
               w_state_nxt = w_accept ? SETUP : IDLE;
            end else if (w_abort) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Command fields stay put after a transfer so the bus only moves on accept.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_cmd <= '0;
      end else if (w_accept) begin
         r_cmd.addr  <= APB_ADDR_W'(bus.cmd_addr);
         r_cmd.write <= bus.cmd_write;
         r_cmd.wdata <= APB_DATA_W'(bus.cmd_wdata);
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
      end else begin
         r_rsp_valid <= w_done || w_abort;
         if (w_done) begin
            r_rsp.rdata   <= r_cmd.write ? '0 : APB_DATA_W'(bus.prdata);
            r_rsp.slverr  <= bus.pslverr;
            r_rsp.timeout <= 1'b0;
         end else if (w_abort) begin
            r_rsp.rdata   <= '0;
            r_rsp.slverr  <= 1'b1;
            r_rsp.timeout <= 1'b1;
         end
      end
   end

   assign bus.cmd_ready   = w_cmd_ready;
   assign bus.pselx       = (r_state != IDLE);
   assign bus.penable     = (r_state == ACCESS);
   assign bus.paddr       = r_cmd.addr[ADDR_W-1:0];
   assign bus.pwrite      = r_cmd.write;
   assign bus.pwdata      = r_cmd.wdata[DATA_W-1:0];
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rsp.rdata[DATA_W-1:0];
   assign bus.rsp_slverr  = r_rsp.slverr;
   assign bus.rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - randomized self-checking bench for apb_requester against a transfer-level model
module tb_apb_requester;

`ifdef APB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO = 4;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      int          waits;
      logic        err;
      logic [31:0] rdata;
   } x_t;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      logic        timeout;
      int          cyc;
      logic        psel;
   } r_t;

   logic pclk = 1'b0;
   logic presetn = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   x_t   xq[$];
   int   acc_cyc[$];
   r_t   rq[$];
   int   psel_cnt, pen_cnt, proto_err;
   bit   run_hung;

   apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_requester #(
      .ADDR_W (32),
      .DATA_W (32)
`ifdef APB_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TO)
`endif
   ) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc++;

   // Expected response of one transfer, from the completer behaviour it saw.
   function automatic r_t model(input x_t x);
      r_t e;
      e.cyc = 0;
      e.psel = 1'b0;
      if (TO_EN && x.waits >= TO) begin
         e.rdata = 32'h0; e.slverr = 1'b1; e.timeout = 1'b1;
      end else begin
         e.rdata = x.write ? 32'h0 : x.rdata; e.slverr = x.err; e.timeout = 1'b0;
      end
      return e;
   endfunction

   function automatic int lat(input x_t x);
      return (TO_EN && x.waits >= TO) ? 2 + TO : 3 + x.waits;
   endfunction

   function automatic x_t rand_x(input int maxw, input bit errs);
      x_t x;
      x.addr  = $urandom & 32'hFFFF_FFFC;
      x.write = 1'($urandom_range(0, 1));
      x.wdata = $urandom;
      x.waits = $urandom_range(0, maxw);
      x.err   = errs ? 1'($urandom_range(0, 1)) : 1'b0;
      x.rdata = $urandom;
      return x;
   endfunction

   // Drives xq as commands and acts as the APB completer; records what it observes.
   task automatic run_xfers(input bit gaps);
      int idx = 0;
      int apb_q[$];
      int wcnt = 0;
      bit active = 1'b0;
      int budget = 0;
      int k;
      r_t r;
      acc_cyc.delete(); rq.delete();
      psel_cnt = 0; pen_cnt = 0; proto_err = 0; run_hung = 1'b0;
      while (rq.size() < xq.size()) begin
         @(negedge pclk);
         budget++;
         if (budget > 1500) begin
            run_hung = 1'b1;
            break;
         end
         if (bus.rsp_valid) begin
            r.rdata = bus.rsp_rdata; r.slverr = bus.rsp_slverr; r.timeout = bus.rsp_timeout;
            r.cyc = cyc; r.psel = bus.pselx;
            rq.push_back(r);
         end
         if (bus.pselx) psel_cnt++;
         if (bus.penable) pen_cnt++;
         if (active && !(bus.pselx && bus.penable)) begin
            void'(apb_q.pop_front()); active = 1'b0; wcnt = 0;
         end
         if (bus.pselx) begin
            if (apb_q.size() == 0) proto_err++;
            else begin
               k = apb_q[0];
               if (bus.paddr !== xq[k].addr || bus.pwrite !== xq[k].write ||
                   (xq[k].write && bus.pwdata !== xq[k].wdata)) proto_err++;
            end
         end
         bus.prdata  = $urandom;
         bus.pslverr = 1'($urandom_range(0, 1));
         bus.pready  = 1'($urandom_range(0, 1));
         if (bus.pselx && bus.penable && apb_q.size() > 0) begin
            k = apb_q[0];
            active = 1'b1;
            if (wcnt < xq[k].waits) begin
               bus.pready = 1'b0; wcnt++;
            end else begin
               bus.pready = 1'b1; bus.prdata = xq[k].rdata; bus.pslverr = xq[k].err;
               void'(apb_q.pop_front()); active = 1'b0; wcnt = 0;
            end
         end
         bus.cmd_valid = 1'b0;
         bus.cmd_addr  = $urandom;
         bus.cmd_write = 1'($urandom_range(0, 1));
         bus.cmd_wdata = $urandom;
         if (idx < xq.size() && !(gaps && $urandom_range(0, 2) == 0)) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_addr  = xq[idx].addr;
            bus.cmd_write = xq[idx].write;
            bus.cmd_wdata = xq[idx].wdata;
         end
         #1;
         if (bus.cmd_valid && bus.cmd_ready) begin
            acc_cyc.push_back(cyc); apb_q.push_back(idx); idx++;
         end
      end
      bus.cmd_valid = 1'b0;
      bus.pready = 1'b0;
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h55; bus.cmd_write = 1'b1; bus.cmd_wdata = 32'h1;
      bus.prdata = 32'h0; bus.pready = 1'b1; bus.pslverr = 1'b0;
      repeat (2) @(negedge pclk);
      n_checks++;
      if ({bus.pselx, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl got %b required 000000",
            {bus.pselx, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout});
      end
      n_checks++;
      if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h required 0",
            bus.paddr, bus.pwdata, bus.rsp_rdata);
      end
      n_checks++;
      if (bus.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_cmd_ready got %b required 0", bus.cmd_ready);
      end
      bus.cmd_valid = 1'b0; bus.pready = 1'b0;
      presetn = 1'b1;
      #1;
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL idle_cmd_ready got %b required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_write_basic();
      xq.delete();
      xq.push_back('{addr:32'h10, write:1'b1, wdata:32'hDEADBEEF, waits:0, err:1'b0, rdata:32'hA5A5A5A5});
      run_xfers(1'b0);
      n_checks++;
      if (run_hung || rq.size() != 1) begin
         n_fail++; $display("FAIL wr_count got %0d hung=%0d required 1", rq.size(), run_hung);
      end else begin
         n_checks++;
         if (psel_cnt != 2 || pen_cnt != 1) begin
            n_fail++; $display("FAIL wr_phases got psel=%0d pen=%0d required 2 1", psel_cnt, pen_cnt);
         end
         n_checks++;
         if (rq[0].slverr !== 1'b0 || rq[0].rdata !== 32'h0 || rq[0].cyc - acc_cyc[0] != 3) begin
            n_fail++; $display("FAIL wr_rsp got err=%b rdata=%h lat=%0d required 0 0 3",
               rq[0].slverr, rq[0].rdata, rq[0].cyc - acc_cyc[0]);
         end
         n_checks++;
         if (proto_err != 0) begin
            n_fail++; $display("FAIL wr_bus got %0d bus errors required 0", proto_err);
         end
      end
   endtask

   task automatic test_read_wait();
      xq.delete();
      xq.push_back('{addr:32'h14, write:1'b0, wdata:32'h0, waits:3, err:1'b0, rdata:32'h12345678});
      run_xfers(1'b0);
      n_checks++;
      if (run_hung || rq.size() != 1) begin
         n_fail++; $display("FAIL rdw_count got %0d hung=%0d required 1", rq.size(), run_hung);
      end else begin
         n_checks++;
         if (psel_cnt != 5 || pen_cnt != 4 || proto_err != 0) begin
            n_fail++; $display("FAIL rdw_stable got psel=%0d pen=%0d buserr=%0d required 5 4 0",
               psel_cnt, pen_cnt, proto_err);
         end
         n_checks++;
         if (rq[0].rdata !== 32'h12345678 || rq[0].slverr !== 1'b0 || rq[0].cyc - acc_cyc[0] != 6) begin
            n_fail++; $display("FAIL rdw_rsp got rdata=%h err=%b lat=%0d required 12345678 0 6",
               rq[0].rdata, rq[0].slverr, rq[0].cyc - acc_cyc[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      r_t e;
      xq.delete();
      for (int i = 0; i < 4; i++) xq.push_back(rand_x(0, 1'b0));
      run_xfers(1'b0);
      n_checks++;
      if (run_hung || rq.size() != 4 || acc_cyc.size() != 4) begin
         n_fail++; $display("FAIL b2b_count got %0d hung=%0d required 4", rq.size(), run_hung);
      end else begin
         for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 2 || rq[i].cyc - rq[i-1].cyc != 2) begin
               n_fail++; $display("FAIL b2b_spacing[%0d] got acc=%0d rsp=%0d required 2 2",
                  i, acc_cyc[i] - acc_cyc[i-1], rq[i].cyc - rq[i-1].cyc);
            end
         end
         n_checks++;
         if (psel_cnt != 8 || rq[3].cyc - acc_cyc[0] - 1 != 8 || proto_err != 0) begin
            n_fail++; $display("FAIL b2b_psel got psel=%0d span=%0d buserr=%0d required 8 8 0",
               psel_cnt, rq[3].cyc - acc_cyc[0] - 1, proto_err);
         end
         for (int i = 0; i < 4; i++) begin
            e = model(xq[i]);
            n_checks++;
            if (rq[i].rdata !== e.rdata || rq[i].slverr !== e.slverr) begin
               n_fail++; $display("FAIL b2b_rsp[%0d] got rdata=%h err=%b required %h %b",
                  i, rq[i].rdata, rq[i].slverr, e.rdata, e.slverr);
            end
         end
      end
   endtask

   task automatic test_slverr();
      xq.delete();
      xq.push_back('{addr:32'h20, write:1'b0, wdata:32'h0, waits:0, err:1'b1, rdata:32'hC0FFEE01});
      xq.push_back('{addr:32'h24, write:1'b1, wdata:32'h0BADF00D, waits:1, err:1'b0, rdata:32'h0});
      run_xfers(1'b0);
      n_checks++;
      if (run_hung || rq.size() != 2) begin
         n_fail++; $display("FAIL err_count got %0d hung=%0d required 2", rq.size(), run_hung);
      end else begin
         n_checks++;
         if (rq[0].slverr !== 1'b1 || rq[0].rdata !== 32'hC0FFEE01 || rq[0].timeout !== 1'b0) begin
            n_fail++; $display("FAIL err_first got err=%b rdata=%h to=%b required 1 c0ffee01 0",
               rq[0].slverr, rq[0].rdata, rq[0].timeout);
         end
         n_checks++;
         if (rq[1].slverr !== 1'b0 || rq[1].rdata !== 32'h0) begin
            n_fail++; $display("FAIL err_next got err=%b rdata=%h required 0 0", rq[1].slverr, rq[1].rdata);
         end
      end
   endtask

   task automatic test_random();
      r_t e;
      xq.delete();
      for (int i = 0; i < 16; i++) xq.push_back(rand_x(5, 1'b1));
      run_xfers(1'b1);
      n_checks++;
      if (run_hung || rq.size() != 16 || acc_cyc.size() != 16 || proto_err != 0) begin
         n_fail++; $display("FAIL rand_count got rsp=%0d acc=%0d hung=%0d buserr=%0d required 16 16 0 0",
            rq.size(), acc_cyc.size(), run_hung, proto_err);
      end else begin
         for (int i = 0; i < 16; i++) begin
            e = model(xq[i]);
            n_checks++;
            if (rq[i].rdata !== e.rdata || rq[i].slverr !== e.slverr || rq[i].timeout !== e.timeout ||
                rq[i].cyc - acc_cyc[i] != lat(xq[i])) begin
               n_fail++; $display("FAIL rand_rsp[%0d] got rdata=%h err=%b to=%b lat=%0d required %h %b %b %0d",
                  i, rq[i].rdata, rq[i].slverr, rq[i].timeout, rq[i].cyc - acc_cyc[i],
                  e.rdata, e.slverr, e.timeout, lat(xq[i]));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      @(negedge pclk);
      bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h30; bus.cmd_write = 1'b0; bus.cmd_wdata = 32'h0;
      bus.pready = 1'b0;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge pclk);
      n_checks++;
      if (bus.pselx !== 1'b1 || bus.penable !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_access got psel=%b pen=%b required 1 1", bus.pselx, bus.penable);
      end
      #2;
      bus.pready = 1'b1;
      presetn = 1'b0;
      #1;
      n_checks++;
      if (bus.pselx !== 1'b0 || bus.penable !== 1'b0 || bus.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_drop got psel=%b pen=%b rdy=%b required 0 0 0",
            bus.pselx, bus.penable, bus.cmd_ready);
      end
      @(negedge pclk);
      presetn = 1'b1;
      bus.pready = 1'b0;
      repeat (4) begin
         @(negedge pclk);
         if (bus.rsp_valid || bus.pselx) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++; $display("FAIL rstmid_quiet got %0d active cycles required 0", pulses);
      end
      xq.delete();
      xq.push_back('{addr:32'h34, write:1'b0, wdata:32'h0, waits:1, err:1'b0, rdata:32'h600DCAFE});
      run_xfers(1'b0);
      n_checks++;
      if (run_hung || rq.size() != 1 || rq[0].rdata !== 32'h600DCAFE || rq[0].cyc - acc_cyc[0] != 4) begin
         n_fail++; $display("FAIL rstmid_after got n=%0d rdata=%h required 1 600dcafe lat 4",
            rq.size(), (rq.size() > 0) ? rq[0].rdata : 32'h0);
      end
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      xq.delete();
      xq.push_back('{addr:32'h40, write:1'b0, wdata:32'h0, waits:1000, err:1'b0, rdata:32'hFFFFFFFF});
      xq.push_back('{addr:32'h44, write:1'b1, wdata:32'h44, waits:0, err:1'b0, rdata:32'h0});
      run_xfers(1'b0);
      n_checks++;
      if (run_hung || rq.size() != 2 || acc_cyc.size() != 2) begin
         n_fail++; $display("FAIL to_count got %0d hung=%0d required 2", rq.size(), run_hung);
      end else begin
         n_checks++;
         if (rq[0].slverr !== 1'b1 || rq[0].timeout !== 1'b1 || rq[0].rdata !== 32'h0 ||
             rq[0].cyc - acc_cyc[0] != 2 + TO) begin
            n_fail++; $display("FAIL to_rsp got err=%b to=%b rdata=%h lat=%0d required 1 1 0 %0d",
               rq[0].slverr, rq[0].timeout, rq[0].rdata, rq[0].cyc - acc_cyc[0], 2 + TO);
         end
         n_checks++;
         if (rq[0].psel !== 1'b0 || acc_cyc[1] != rq[0].cyc + 1) begin
            n_fail++; $display("FAIL to_idle got psel=%b next_acc=%0d required 0 %0d",
               rq[0].psel, acc_cyc[1], rq[0].cyc + 1);
         end
         n_checks++;
         if (rq[1].slverr !== 1'b0 || rq[1].timeout !== 1'b0 || proto_err != 0) begin
            n_fail++; $display("FAIL to_next got err=%b to=%b buserr=%0d required 0 0 0",
               rq[1].slverr, rq[1].timeout, proto_err);
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_basic();
      test_read_wait();
      test_back_to_back();
      test_slverr();
      test_random();
      test_reset_mid();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
